// File: rtl/poci_pkg.sv
// Shared types and constants for the POCI (peripheral-out) serializer.
package poci_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      SHIFT
   } poci_state_t;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned ADDR_W_DEFAULT = 8;

endpackage

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shift register, MSB first, zero fill; load wins over shift.
module piso_shift_register #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              sclk,
   input  logic              rstn,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              msb_o
);

   logic [DATA_W-1:0] shreg_q, shreg_d;

   always_comb begin
      shreg_d = shreg_q;
      if (load_i) begin
         shreg_d = data_i;
      end else if (shift_i) begin
         shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign msb_o = shreg_q[DATA_W-1];

endmodule

// File: rtl/poci_serializer.sv
// POCI transmitter: streams register-file bytes MSB-first from a start address,
// auto-incrementing the read address until reset ends the transaction.
module poci_serializer
   import poci_pkg::*;
#(
   parameter int unsigned DATA_W = BYTE_W,
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              sclk,
   input  logic              rstn,
   input  logic              addr_valid_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [DATA_W-1:0] read_data_i,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic              serial_out_o,
   output logic              byte_done_o,
   output logic              active_o
);

   localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

   poci_state_t       state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic              byte_done_q, byte_done_d;
   logic              load, shift;

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      bit_cnt_d   = bit_cnt_q;
      byte_done_d = 1'b0;
      load        = 1'b0;
      shift       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (addr_valid_i) begin
               rd_addr_d = start_addr_i;
               state_d   = ARM;
            end
         end
         ARM: begin
            // rd_addr has had a full period to settle the mux; prefetch the next one
            load      = 1'b1;
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            bit_cnt_d = '0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            if (bit_cnt_q == CntLast) begin
               load      = 1'b1;
               rd_addr_d = rd_addr_q + ADDR_W'(1);
               bit_cnt_d = '0;
            end else begin
               shift       = 1'b1;
               bit_cnt_d   = bit_cnt_q + CntW'(1);
               byte_done_d = (bit_cnt_q == CntLast - CntW'(1));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         rd_addr_q   <= '0;
         bit_cnt_q   <= '0;
         byte_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_done_q <= byte_done_d;
      end
   end

   piso_shift_register #(
      .DATA_W(DATA_W)
   ) u_piso (
      .sclk   (sclk),
      .rstn   (rstn),
      .load_i (load),
      .shift_i(shift),
      .data_i (read_data_i),
      .msb_o  (serial_out_o)
   );

   assign rd_addr_o   = rd_addr_q;
   assign byte_done_o = byte_done_q;
   assign active_o    = (state_q != IDLE);

endmodule

// File: tb/tb_poci_serializer.sv
// Directed bench for poci_serializer with a behavioural register-file read mux.
module tb_poci_serializer;

   logic       sclk;
   logic       rstn;
   logic       addr_valid;
   logic [7:0] start_addr;
   logic [7:0] read_data;
   logic [7:0] rd_addr;
   logic       serial_out;
   logic       byte_done;
   logic       active;

   logic [7:0] mem [256];

   int checks;
   int errors;

   poci_serializer #(
      .DATA_W(8),
      .ADDR_W(8)
   ) dut (
      .sclk        (sclk),
      .rstn        (rstn),
      .addr_valid_i(addr_valid),
      .start_addr_i(start_addr),
      .read_data_i (read_data),
      .rd_addr_o   (rd_addr),
      .serial_out_o(serial_out),
      .byte_done_o (byte_done),
      .active_o    (active)
   );

   assign read_data = mem[rd_addr];

   initial begin
      sclk = 1'b0;
      forever #5 sclk = ~sclk;
   end

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic do_reset();
      addr_valid = 1'b0;
      rstn       = 1'b0;
      #1;
      @(negedge sclk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn       = 1'b0;
      addr_valid = 1'b0;
      start_addr = 8'h00;
      #2;
      checks++;
      if ({serial_out, byte_done, active, rd_addr} !== 11'h000) begin
         errors++;
         $display("FAIL reset_values: got so=%b bd=%b act=%b rd=%h, want 0 0 0 00",
                  serial_out, byte_done, active, rd_addr);
      end
      @(negedge sclk);
      rstn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({serial_out, active, rd_addr} !== 10'h000) begin
            errors++;
            $display("FAIL idle_hold[%0d]: got so=%b act=%b rd=%h, want 0 0 00",
                     i, serial_out, active, rd_addr);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3];
      logic [7:0] b;
      bytes[0] = 8'hA5;
      bytes[1] = 8'h3C;
      bytes[2] = 8'hFF;
      do_reset();
      addr_valid = 1'b1;
      start_addr = 8'h05;
      tick();
      addr_valid = 1'b0;
      checks++;
      if (rd_addr !== 8'h05 || active !== 1'b1 || serial_out !== 1'b0) begin
         errors++;
         $display("FAIL b2b_e0: got rd=%h act=%b so=%b, want 05 1 0", rd_addr, active, serial_out);
      end
      for (int i = 0; i < 24; i++) begin
         tick();
         b = bytes[i / 8];
         checks++;
         if (serial_out !== b[7 - (i % 8)] || byte_done !== (i % 8 == 7) || active !== 1'b1) begin
            errors++;
            $display("FAIL b2b_bit[E%0d]: got so=%b bd=%b act=%b, want %b %b 1",
                     i + 1, serial_out, byte_done, active, b[7 - (i % 8)], (i % 8 == 7));
         end
         if (i % 8 == 0) begin
            checks++;
            if (rd_addr !== 8'(6 + i / 8)) begin
               errors++;
               $display("FAIL b2b_addr[E%0d]: got %h, want %h", i + 1, rd_addr, 8'(6 + i / 8));
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] bytes [2];
      logic [7:0] b;
      bytes[0] = 8'h81;
      bytes[1] = 8'h7E;
      do_reset();
      addr_valid = 1'b1;
      start_addr = 8'hFF;
      tick();
      addr_valid = 1'b0;
      checks++;
      if (rd_addr !== 8'hFF) begin
         errors++;
         $display("FAIL wrap_e0_addr: got %h, want ff", rd_addr);
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         b = bytes[i / 8];
         checks++;
         if (serial_out !== b[7 - (i % 8)] || byte_done !== (i % 8 == 7)) begin
            errors++;
            $display("FAIL wrap_bit[E%0d]: got so=%b bd=%b, want %b %b",
                     i + 1, serial_out, byte_done, b[7 - (i % 8)], (i % 8 == 7));
         end
         if (i % 8 == 0) begin
            checks++;
            if (rd_addr !== 8'(i / 8)) begin
               errors++;
               $display("FAIL wrap_addr[E%0d]: got %h, want %h", i + 1, rd_addr, 8'(i / 8));
            end
         end
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] b;
      do_reset();
      addr_valid = 1'b1;
      start_addr = 8'h10;
      tick();
      addr_valid = 1'b0;
      b = 8'hF0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (serial_out !== b[7 - i]) begin
            errors++;
            $display("FAIL areset_pre_bit[E%0d]: got %b, want %b", i + 1, serial_out, b[7 - i]);
         end
      end
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if ({serial_out, byte_done, active, rd_addr} !== 11'h000) begin
         errors++;
         $display("FAIL areset_clear: got so=%b bd=%b act=%b rd=%h, want 0 0 0 00",
                  serial_out, byte_done, active, rd_addr);
      end
      @(negedge sclk);
      rstn       = 1'b1;
      addr_valid = 1'b1;
      start_addr = 8'h20;
      tick();
      addr_valid = 1'b0;
      b = 8'h96;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (serial_out !== b[7 - i] || byte_done !== (i == 7)) begin
            errors++;
            $display("FAIL areset_restart_bit[E%0d]: got so=%b bd=%b, want %b %b",
                     i + 1, serial_out, byte_done, b[7 - i], (i == 7));
         end
         if (i == 0) begin
            checks++;
            if (rd_addr !== 8'h21) begin
               errors++;
               $display("FAIL areset_restart_addr: got %h, want 21", rd_addr);
            end
         end
      end
   endtask

   task automatic test_ignore_rearm();
      logic [7:0] bytes [2];
      logic [7:0] b;
      bytes[0] = 8'h5A;
      bytes[1] = 8'hC6;
      do_reset();
      addr_valid = 1'b1;
      start_addr = 8'h30;
      tick();
      addr_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 2) begin
            addr_valid = 1'b1;
            start_addr = 8'h40;
         end else if (i == 5) begin
            addr_valid = 1'b0;
         end
         b = bytes[i / 8];
         checks++;
         if (serial_out !== b[7 - (i % 8)] || active !== 1'b1) begin
            errors++;
            $display("FAIL rearm_bit[E%0d]: got so=%b act=%b, want %b 1",
                     i + 1, serial_out, active, b[7 - (i % 8)]);
         end
         if (i % 8 == 0) begin
            checks++;
            if (rd_addr !== 8'(8'h31 + i / 8)) begin
               errors++;
               $display("FAIL rearm_addr[E%0d]: got %h, want %h",
                        i + 1, rd_addr, 8'(8'h31 + i / 8));
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h05] = 8'hA5;
      mem[8'h06] = 8'h3C;
      mem[8'h07] = 8'hFF;
      mem[8'hFF] = 8'h81;
      mem[8'h00] = 8'h7E;
      mem[8'h10] = 8'hF0;
      mem[8'h20] = 8'h96;
      mem[8'h30] = 8'h5A;
      mem[8'h31] = 8'hC6;
      mem[8'h40] = 8'hFF;
      mem[8'h41] = 8'hFF;

      test_reset();
      test_back_to_back();
      test_wrap();
      test_async_reset();
      test_ignore_rearm();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/poci_serializer.md
# poci_serializer

Parallel-to-serial transmitter for the peripheral-out/controller-in (POCI) direction of the SPI link. It takes a start register address from the receive side and reads bytes from the register file through the read mux. It shifts each byte out MSB-first on `sclk`, auto-incrementing the read address after every byte until reset ends the transaction. It sits beside the PICO receive path and shares its `sclk` and combined reset (external reset AND sclk-stop reset).

## Interface
Parameters:
- `DATA_W`, 8: bits per serial word.
- `ADDR_W`, 8: width of register address.

Ports:
- `sclk`  in  1  SPI clock; all state updates on rising edge.
- `rstn`  in  1  asynchronous, active-low reset; clock `sclk`. Driven by the combined external/sclk-stop reset.
- `addr_valid`  in  1  start address is valid; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first register address to read.
- `read_data`  in  DATA_W  register contents at `rd_addr`, from the read mux (combinational, settles within one sclk period).
- `rd_addr`  out  ADDR_W  read-mux select.
- `serial_out`  out  1  POCI data line; registered.
- `byte_done`  out  1  one-cycle pulse while the last bit of a byte is on the line.
- `active`  out  1  high in ARM and SHIFT.

## Operation
- States: IDLE, ARM, SHIFT.
- IDLE:
  - `serial_out`=0, `active`=0.
  - On an edge with `addr_valid`=1: `rd_addr`<=`start_addr`, go to ARM.
  - Otherwise hold.
- ARM, one cycle for mux settling:
  - shift register <= `read_data`.
  - `rd_addr`<=`rd_addr`+1 (prefetch address).
  - `bit_cnt`<=0.
  - Go to SHIFT.
- SHIFT, on each edge:
  - If `bit_cnt`<DATA_W-1: shift register <= shift register << 1 (zero fill), `bit_cnt`++.
  - If `bit_cnt`==DATA_W-1: shift register <= `read_data`, `rd_addr`<=`rd_addr`+1, `bit_cnt`<=0. Back-to-back byte, no gap.
- `serial_out` = MSB of shift register (register output, no combinational path from inputs).
- `byte_done` registered: set on the edge where `bit_cnt` becomes DATA_W-1, cleared on the next edge.
- Address arithmetic is modulo 2^ADDR_W: 8'hFF+1 = 8'h00, silently wraps.
- `addr_valid` is ignored outside IDLE; no re-arm mid-transaction.
- Only `rstn` exits SHIFT. The sclk-stop reset terminates the transaction.

## Timing
- Reset values: state IDLE, `rd_addr`=0, shift register=0, `bit_cnt`=0, `serial_out`=0, `byte_done`=0, `active`=0.
- `rstn` low at any time, including mid-byte: immediate async clear to the reset values. The partial byte is dropped.
- Edge numbering, with E0 the edge sampling `addr_valid`=1:
  - After E0: `rd_addr`=start_addr.
  - After E1: MSB of mem[start_addr] on `serial_out`, `rd_addr`=start_addr+1.
  - After E1+k: bit DATA_W-1-k on the line, k=0..7. LSB appears after E8, with `byte_done`=1 for that cycle.
  - After E9: MSB of mem[start_addr+1], `rd_addr`=start_addr+2.
- Each bit is stable for one full sclk period. The controller samples on the falling edge.
- `read_data` must be valid for `rd_addr` one full period after `rd_addr` changes.

## Structure
- Package `poci_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ARM, SHIFT} poci_state_t`.
  - `BYTE_W`=8.
  - `ADDR_W_DEFAULT`=8.
- `bit_cnt` width is $clog2(DATA_W).
- Sub-module `piso_shift_register` (DATA_W param; `load`, `shift` enables; MSB out) holds the shift register. Address counter and FSM stay in the top.

## Test plan
- Reset, then hold `addr_valid`=0 for 20 edges -> `serial_out`=0, `active`=0, `rd_addr`=0 throughout.
- `start_addr`=8'h05, mem[5]=8'hA5, one `addr_valid` pulse -> after E1..E8 line reads 1,0,1,0,0,1,0,1; `byte_done`=1 only after E8; `rd_addr`=8'h06 after E1.
- Continue 16 more edges with mem[6]=8'h3C, mem[7]=8'hFF -> 0x3C then 0xFF with no idle bit between bytes; `rd_addr` 7 then 8.
- `start_addr`=8'hFF, mem[FF]=8'h81, mem[0]=8'h7E -> 0x81 then 0x7E; `rd_addr` wraps to 8'h00 after E1 and reads 8'h01 after E9.
- Assert `rstn` low asynchronously between edges mid-byte (after E4) -> all outputs at reset values immediately. A new `addr_valid` after release restarts from the new `start_addr` MSB.
- Toggle `addr_valid` with a different `start_addr` during SHIFT -> ignored; the stream continues from the original address sequence.
